// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and round-constant lookup for the AES-128
// key schedule controller and its round-key storage.
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;
  localparam int RW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  // RCON[1..10]; index 0 and anything above 10 have no round constant.
  function automatic logic [7:0] rcon_byte(input logic [RW-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/round_key_regfile.sv
// Round-key storage: one write port, one registered read port that returns
// zero for indices past the last entry. Reads see the pre-write contents.
module round_key_regfile
  import aes_pkg::*;
#(
  parameter int DEPTH = NR + 1,
  parameter int W     = KEY_W,
  parameter int AW    = RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i && (waddr_i <= LAST_IDX)) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= (raddr_i <= LAST_IDX) ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Sequences the AES-128 key expander (load pulse + RCON per round) and
// captures the NR+1 round keys it emits into a randomly readable buffer.
module aes_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             exp_load_enable,
  output logic [31:0]      exp_rcon,
  input  logic [KEY_W-1:0] exp_key,
  output logic             busy,
  output logic             keys_ready,
  input  logic [RW-1:0]    rd_round,
  output logic [KEY_W-1:0] rd_key,
  output state_e           dbg_state
);

  localparam logic [RW-1:0] LAST_J = RW'(NR);

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          load_en_q, load_en_d;
  logic [31:0]   rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  // start is only looked at in IDLE/READY, so a request while busy is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (cnt_q == LAST_J) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state/counter so they line up with
  // the state they describe and never see start combinationally.
  always_comb begin
    load_en_d = (state_d == ST_LOAD);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_EXPAND);
    ready_d   = (state_d == ST_READY);
    rcon_d    = '0;
    if ((state_d == ST_EXPAND) && (cnt_d != LAST_J)) begin
      rcon_d = {rcon_byte(cnt_d + 1'b1), 24'h000000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      load_en_q <= 1'b0;
      rcon_q    <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_en_q <= load_en_d;
      rcon_q    <= rcon_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  round_key_regfile #(
    .DEPTH (NR + 1),
    .W     (KEY_W),
    .AW    (RW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (state_q == ST_EXPAND),
    .waddr_i (cnt_q),
    .wdata_i (exp_key),
    .raddr_i (rd_round),
    .rdata_o (rd_key)
  );

  assign exp_load_enable = load_en_q;
  assign exp_rcon        = rcon_q;
  assign busy            = busy_q;
  assign keys_ready      = ready_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for aes_key_schedule_ctrl with a table-driven stand-in for
// the key expander (FIPS-197 A.1 key and the all-zero key).
module tb_aes_key_schedule_ctrl;
  import aes_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         exp_load_enable;
  logic [31:0]  exp_rcon;
  logic [127:0] exp_key;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  state_e       dbg_state;

  int n_checks;
  int n_fail;
  int key_sel;

  // Expander stand-in: round-key sequences for key 0 (FIPS A.1) and key 1 (zero key).
  logic [127:0] key_tbl [0:1][0:10] = '{
    '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0c8bb6630ca6},
    '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
      128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
      128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'hb4ef5bcb3e92e21123e951cf6f8f188e}
  };

  logic [31:0] rcon_exp [0:10] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000,
    32'h00000000
  };

  logic [3:0] mdl_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                mdl_idx <= 4'd15;
    else if (exp_load_enable)  mdl_idx <= 4'd0;
    else if (mdl_idx != 4'd15) mdl_idx <= mdl_idx + 4'd1;
  end

  assign exp_key = (mdl_idx <= 4'd10) ? key_tbl[key_sel][mdl_idx] : {4{32'hdeadbeef}};

  aes_key_schedule_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .exp_load_enable (exp_load_enable),
    .exp_rcon        (exp_rcon),
    .exp_key         (exp_key),
    .busy            (busy),
    .keys_ready      (keys_ready),
    .rd_round        (rd_round),
    .rd_key          (rd_key),
    .dbg_state       (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic do_start(input int sel);
    @(negedge clk);
    key_sel = sel;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; rd_round = 4'd0; key_sel = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_load_enable !== 1'b0 || exp_rcon !== 32'h0 || busy !== 1'b0 ||
        keys_ready !== 1'b0 || rd_key !== 128'h0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: le=%b rcon=%h busy=%b rdy=%b rd_key=%h st=%0d, required all zero/IDLE",
               exp_load_enable, exp_rcon, busy, keys_ready, rd_key, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_a1;
    logic [127:0] exp_v [0:2];
    int           rr [0:2];
    exp_v = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
              128'hd014f9a8c9ee2589e13f0c8bb6630ca6};
    rr = '{0, 1, 10};
    do_start(0);
    n_checks++;
    if (exp_load_enable !== 1'b1 || busy !== 1'b1 || exp_rcon !== 32'h0 || keys_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_cycle: le=%b busy=%b rcon=%h rdy=%b, required 1 1 00000000 0",
               exp_load_enable, busy, exp_rcon, keys_ready);
    end
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      n_checks++;
      if (exp_load_enable !== 1'b0 || busy !== 1'b1 || keys_ready !== 1'b0 || exp_rcon !== rcon_exp[j]) begin
        n_fail++;
        $display("FAIL expand_j%0d: le=%b busy=%b rdy=%b rcon=%h, required 0 1 0 %h",
                 j, exp_load_enable, busy, keys_ready, exp_rcon, rcon_exp[j]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (keys_ready !== 1'b1 || busy !== 1'b0 || exp_rcon !== 32'h0 || dbg_state !== ST_READY) begin
      n_fail++;
      $display("FAIL ready_after_e12: rdy=%b busy=%b rcon=%h st=%0d, required 1 0 00000000 READY",
               keys_ready, busy, exp_rcon, dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      rd_round = 4'(rr[i]);
      @(negedge clk);
      n_checks++;
      if (rd_key !== exp_v[i]) begin
        n_fail++;
        $display("FAIL a1_round%0d: got %h, required %h", rr[i], rd_key, exp_v[i]);
      end
    end
  endtask

  task automatic test_read_boundary;
    logic [127:0] prev;
    rd_round = 4'd1;
    @(negedge clk);
    rd_round = 4'd11;
    @(negedge clk);
    n_checks++;
    if (rd_key !== 128'h0) begin
      n_fail++;
      $display("FAIL read_idx11: got %h, required 0", rd_key);
    end
    rd_round = 4'd3;
    @(negedge clk);
    rd_round = 4'd15;
    @(negedge clk);
    n_checks++;
    if (rd_key !== 128'h0) begin
      n_fail++;
      $display("FAIL read_idx15: got %h, required 0", rd_key);
    end
    prev = 128'h0;
    for (int r = 10; r >= 0; r--) begin
      rd_round = 4'(r);
      #1;
      n_checks++;
      if (rd_key !== prev) begin
        n_fail++;
        $display("FAIL rev_latency_r%0d: got %h before edge, required %h", r, rd_key, prev);
      end
      @(negedge clk);
      n_checks++;
      if (rd_key !== key_tbl[0][r]) begin
        n_fail++;
        $display("FAIL rev_round%0d: got %h, required %h", r, rd_key, key_tbl[0][r]);
      end
      prev = key_tbl[0][r];
    end
  endtask

  task automatic test_start_during_expand;
    int ready_cyc;
    int le_seen;
    ready_cyc = -1;
    le_seen   = 0;
    do_start(0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
      if (exp_load_enable) le_seen++;
      if (keys_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (ready_cyc != 12 || le_seen != 0) begin
      n_fail++;
      $display("FAIL busy_start_timing: ready after %0d edges, reloads %0d, required 12 and 0",
               ready_cyc, le_seen);
    end
    for (int r = 0; r <= 10; r++) begin
      rd_round = 4'(r);
      @(negedge clk);
      n_checks++;
      if (rd_key !== key_tbl[0][r]) begin
        n_fail++;
        $display("FAIL busy_start_round%0d: got %h, required %h", r, rd_key, key_tbl[0][r]);
      end
    end
  endtask

  task automatic test_restart_ready;
    int ready_cyc;
    ready_cyc = -1;
    do_start(1);
    n_checks++;
    if (keys_ready !== 1'b0 || exp_load_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_drop: rdy=%b le=%b, required 0 1", keys_ready, exp_load_enable);
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (keys_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    n_checks++;
    if (ready_cyc != 12) begin
      n_fail++;
      $display("FAIL restart_timing: ready after %0d edges, required 12", ready_cyc);
    end
    rd_round = 4'd1;
    @(negedge clk);
    n_checks++;
    if (rd_key !== 128'h62636363626363636263636362636363) begin
      n_fail++;
      $display("FAIL zero_round1: got %h, required 62636363626363636263636362636363", rd_key);
    end
    rd_round = 4'd10;
    @(negedge clk);
    n_checks++;
    if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      n_fail++;
      $display("FAIL zero_round10: got %h, required b4ef5bcb3e92e21123e951cf6f8f188e", rd_key);
    end
    rd_round = 4'd0;
    @(negedge clk);
    n_checks++;
    if (rd_key !== 128'h0) begin
      n_fail++;
      $display("FAIL zero_round0: got %h, required 0", rd_key);
    end
  endtask

  task automatic test_reset_mid_expand;
    do_start(0);
    repeat (7) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || exp_rcon !== rcon_exp[6]) begin
      n_fail++;
      $display("FAIL pre_reset_j6: busy=%b rcon=%h, required 1 %h", busy, exp_rcon, rcon_exp[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || keys_ready !== 1'b0 || exp_load_enable !== 1'b0 ||
        exp_rcon !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b rdy=%b le=%b rcon=%h st=%0d, required 0 0 0 0 IDLE",
               busy, keys_ready, exp_load_enable, exp_rcon, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      rd_round = 4'(r);
      @(negedge clk);
      n_checks++;
      if (rd_key !== 128'h0) begin
        n_fail++;
        $display("FAIL cleared_round%0d: got %h, required 0", r, rd_key);
      end
    end
    n_checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || keys_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: st=%0d busy=%b rdy=%b, required IDLE 0 0",
               dbg_state, busy, keys_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fips_a1();
    test_read_boundary();
    test_start_during_expand();
    test_restart_ready();
    test_reset_mid_expand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
- Controller and storage stage directly downstream of the AES-128 key expansion logic.
- On a start request it drives the expander's load_enable and rcon_in inputs, then captures the 11 round keys the expander produces (one per cycle) into an internal register file.
- It exposes a registered random-access read port, so the cipher/inverse-cipher round engine can fetch any round key, in forward or reverse order.

Parameters:
- NR, 10, number of rounds; fixed for AES-128; buffer depth is NR+1.
- KEY_W, 128, round key width in bits.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to expand the cipher key presented on the expander's key_in.
- exp_load_enable, output, 1, drives the expander's load_enable.
- exp_rcon, output, 32, drives the expander's rcon_in; rcon byte in bits [31:24], bits [23:0] are zero.
- exp_key, input, 128, the expander's key_out.
- busy, output, 1, expansion in progress.
- keys_ready, output, 1, all NR+1 round keys are valid.
- rd_round, input, 4, round index to read (0..NR).
- rd_key, output, 128, round key selected by rd_round; 1-cycle registered latency.

Behaviour:
- Reset values: exp_load_enable=0, exp_rcon=0, busy=0, keys_ready=0, rd_key=0, all buffer entries=0, FSM=IDLE, round counter=0. Reset takes effect immediately when asserted, at any point.
- FSM states: IDLE, LOAD, EXPAND, READY.
- IDLE: start=1 -> LOAD.
- LOAD: lasts exactly 1 cycle.
  - exp_load_enable=1, exp_rcon=0, busy=1.
  - Clears keys_ready and resets the counter to j=0.
  - -> EXPAND.
- EXPAND: lasts NR+1 cycles, counter j=0..NR.
  - In cycle j, exp_key holds round key j. It is written to buf[j] at the closing edge.
  - exp_rcon = RCON[j+1] for j<NR; exp_rcon=0 for j=NR.
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - exp_load_enable=0, busy=1.
  - After j=NR: -> READY, busy=0, keys_ready=1.
- READY: keys_ready=1, outputs idle. start=1 -> LOAD, and keys_ready deasserts in the next cycle.
- All control outputs are registered and decoded from state/counter only; there is no combinational start->exp_load_enable path.
- Timing: start sampled at edge E0 -> exp_load_enable high between E0 and E1 -> buf[k] written at edge E(k+2) -> keys_ready high after E(NR+2) = E12.
- start while busy (LOAD or EXPAND) is ignored; the expansion in progress is not disturbed.
- Read port:
  - rd_key <= buf[rd_round] on every clock edge.
  - rd_round > NR -> rd_key <= 0.
  - Reads are allowed at any time. During EXPAND, stale or partially updated entries may be returned; a consumer treats data as valid only while keys_ready=1.
  - A read of buf[j] in the same cycle buf[j] is written returns the old value (no write-through).
- Reset mid-expansion returns the block to IDLE and clears the buffer. A fresh start is required.
- The expander's own synchronous reset is driven outside this block.

Decomposition:
- Shared package aes_pkg holds:
  - constants NR=10, KEY_W=128;
  - RCON table indexed 1..10;
  - FSM state encoding for IDLE/LOAD/EXPAND/READY.
- One sub-module, round_key_regfile: NR+1 x KEY_W storage with asynchronous active-low clear, one write port (we, waddr, wdata) and one registered read port with out-of-range-returns-zero.
- The FSM, counter and rcon selection stay in the top module.

Test Plan:
- FIPS-197 A.1: expander key_in=2b7e151628aed2a6abf7158809cf4f3c, pulse start.
  - keys_ready rises 12 edges after start.
  - rd_round=0 -> 2b7e1516_28aed2a6_abf71588_09cf4f3c.
  - rd_round=1 -> a0fafe17_88542cb1_23a33939_2a6c7605.
  - rd_round=10 -> d014f9a8_c9ee2589_e13f0c8b_b6630ca6.
- Control sequencing: check exp_load_enable is high for exactly one cycle after start, and that exp_rcon steps 01000000,02000000,...,36000000, then 00000000 across EXPAND j=0..10.
- Start during EXPAND (j=4) -> ignored; round keys identical to the undisturbed run; keys_ready timing unchanged.
- Restart in READY with a second key (all-zero) -> keys_ready drops the cycle after LOAD; then round 1 = 62636363_62636363_62636363_62636363 and round 10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- rst_n asserted asynchronously mid-EXPAND (j=6) -> busy/keys_ready/exp_load_enable fall immediately; after release, rd_round=0..10 all read 0 and the block is in IDLE.
- Read boundary: rd_round=11 and 15 -> rd_key=0 one cycle later; reverse sweep 10..0 in READY returns the expected FIPS keys, each with 1-cycle latency.
